// File: rtl/cska_operand_result_stage_if.sv
// Bundle of the upstream operand handshake, the adder-side operand/result wires
// and the downstream result handshake of the carry-skip adder pipeline wrapper.
interface cska_operand_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_acc;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;
  logic             res_zero;
  logic [WIDTH-1:0] acc_q;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holding valid keeps its payload stable until that edge.
  modport slave (
    input  in_valid, in_a, in_b, in_acc, add_sum, add_cout, res_ready,
    output in_ready, add_a, add_b, res_valid, res_sum, res_cout, res_ovf,
           res_zero, acc_q
  );

  modport master (
    output in_valid, in_a, in_b, in_acc, add_sum, add_cout, res_ready,
    input  in_ready, add_a, add_b, res_valid, res_sum, res_cout, res_ovf,
           res_zero, acc_q
  );
endinterface

// File: rtl/cska_operand_result_stage.sv
// Operand register in front of the combinational carry-skip adder and a 2-entry
// result skid buffer behind it, with an optional running-sum accumulator.
module cska_operand_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic                        clk,
  input logic                        rst,
  cska_operand_result_stage_if.slave io_bus
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int MSB = WIDTH - 1;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_head;
  logic [WIDTH-1:0] r_buf_sum  [DEPTH];
  logic             r_buf_cout [DEPTH];
  logic             r_buf_ovf  [DEPTH];
  logic             r_buf_zero [DEPTH];

  logic             w_full;
  logic             w_res_valid;
  logic             w_pop;
  logic             w_s1_adv;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_ovf;
  logic             w_zero;
  logic             w_wr_idx;
  logic [WIDTH-1:0] w_acc_next;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_res_valid = (r_count != '0);
  assign w_pop       = w_res_valid && io_bus.res_ready;
  assign w_s1_adv    = r_s1_valid && (!w_full || w_pop);
  assign w_in_ready  = !r_s1_valid || w_s1_adv;
  assign w_accept    = io_bus.in_valid && w_in_ready;

  assign w_ovf  = (r_add_a[MSB] == r_add_b[MSB]) && (io_bus.add_sum[MSB] != r_add_a[MSB]);
  assign w_zero = (io_bus.add_sum == '0);

  // Forward the sum being captured this edge so a back-to-back accumulate op
  // sees the accumulator as it will be when it reaches the adder.
  assign w_acc_next = w_s1_adv ? io_bus.add_sum : r_acc;

  // With two entries, head+count mod 2 is the free slot; at count=2 that is the
  // head slot, which is exactly the one being popped in a push+pop cycle.
  assign w_wr_idx = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_head     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_sum[i]  <= '0;
        r_buf_cout[i] <= 1'b0;
        r_buf_ovf[i]  <= 1'b0;
        r_buf_zero[i] <= 1'b0;
      end
    end else begin
      if (w_accept) begin
        r_add_a    <= io_bus.in_acc ? w_acc_next : io_bus.in_a;
        r_add_b    <= io_bus.in_b;
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_acc                <= io_bus.add_sum;
        r_buf_sum[w_wr_idx]  <= io_bus.add_sum;
        r_buf_cout[w_wr_idx] <= io_bus.add_cout;
        r_buf_ovf[w_wr_idx]  <= w_ovf;
        r_buf_zero[w_wr_idx] <= w_zero;
      end

      if (w_pop) begin
        r_head <= ~r_head;
      end

      unique case ({w_s1_adv, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.add_a     = r_add_a;
  assign io_bus.add_b     = r_add_b;
  assign io_bus.res_valid = w_res_valid;
  assign io_bus.res_sum   = r_buf_sum[r_head];
  assign io_bus.res_cout  = r_buf_cout[r_head];
  assign io_bus.res_ovf   = r_buf_ovf[r_head];
  assign io_bus.res_zero  = r_buf_zero[r_head];
  assign io_bus.acc_q     = r_acc;
endmodule

// File: tb/tb_cska_operand_result_stage.sv
// Directed bench for cska_operand_result_stage with a behavioural adder model.
module tb_cska_operand_result_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  cska_operand_result_stage_if #(.WIDTH(32)) bus ();

  cska_operand_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Reference 32-bit adder standing in for the carry-skip adder
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic acc, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.in_acc   = acc;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_res_valid", {31'b0, bus.res_valid}, 32'h0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'h1);
    check("rst_acc",       bus.acc_q,   32'h0);
    check("rst_add_a",     bus.add_a,   32'h0);
    check("rst_add_b",     bus.add_b,   32'h0);
    check("rst_res_sum",   bus.res_sum, 32'h0);
    check("rst_flags", {29'b0, bus.res_cout, bus.res_ovf, bus.res_zero}, 32'h0);

    // Single add with latency check
    drive(1'b1, 1'b0, 32'h5, 32'h3);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("single_add_a", bus.add_a, 32'h5);
    check("single_add_b", bus.add_b, 32'h3);
    check("single_early_valid", {31'b0, bus.res_valid}, 32'h0);
    tick();
    check("single_valid", {31'b0, bus.res_valid}, 32'h1);
    check("single_sum",   bus.res_sum, 32'h8);
    check("single_flags", {29'b0, bus.res_cout, bus.res_ovf, bus.res_zero}, 32'h0);
    check("single_acc",   bus.acc_q, 32'h8);
    bus.res_ready = 1'b1;
    tick();
    check("single_drained", {31'b0, bus.res_valid}, 32'h0);

    // Carry-out with zero result, then signed overflow
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("carry_sum",   bus.res_sum, 32'h0);
    check("carry_flags", {29'b0, bus.res_cout, bus.res_ovf, bus.res_zero}, 32'b100 | 32'b001);
    tick();
    check("ovf_sum",   bus.res_sum, 32'h8000_0000);
    check("ovf_flags", {29'b0, bus.res_cout, bus.res_ovf, bus.res_zero}, 32'b010);
    tick();
    check("ovf_drained", {31'b0, bus.res_valid}, 32'h0);
    check("ovf_acc", bus.acc_q, 32'h8000_0000);

    // Accumulate chain 1,2,3,4 back to back with in_a ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1);
    tick();
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h2);
    tick();
    check("acc_r1", bus.res_sum, 32'd1);
    check("acc_r1_valid", {31'b0, bus.res_valid}, 32'h1);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h3);
    tick();
    check("acc_r2", bus.res_sum, 32'd3);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h4);
    tick();
    check("acc_r3", bus.res_sum, 32'd6);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("acc_r4", bus.res_sum, 32'd10);
    check("acc_r4_valid", {31'b0, bus.res_valid}, 32'h1);
    check("acc_final", bus.acc_q, 32'd10);
    tick();
    check("acc_drained", {31'b0, bus.res_valid}, 32'h0);

    // Backpressure: 2 buffered, third held in stage 1
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h100, 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h200, 32'h2);
    tick();
    drive(1'b1, 1'b0, 32'h300, 32'h3);
    tick();
    drive(1'b1, 1'b0, 32'h400, 32'h4);
    #1;
    check("bp_in_ready", {31'b0, bus.in_ready}, 32'h0);
    check("bp_hold_a", bus.add_a, 32'h300);
    check("bp_head", bus.res_sum, 32'h101);
    tick();
    check("bp_stable_sum",   bus.res_sum, 32'h101);
    check("bp_stable_ready", {31'b0, bus.in_ready}, 32'h0);
    check("bp_stable_b", bus.add_b, 32'h3);

    // Push and pop on the same edge while full
    bus.res_ready = 1'b1;
    #1;
    check("pp_in_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus.res_ready = 1'b0;
    #1;
    check("pp_still_full", {31'b0, bus.in_ready}, 32'h0);
    check("bp_r2", bus.res_sum, 32'h202);
    check("pp_s1_a", bus.add_a, 32'h400);
    bus.res_ready = 1'b1;
    tick();
    check("bp_r3", bus.res_sum, 32'h303);
    tick();
    check("bp_r4", bus.res_sum, 32'h404);
    check("bp_r4_valid", {31'b0, bus.res_valid}, 32'h1);
    tick();
    check("bp_drained", {31'b0, bus.res_valid}, 32'h0);

    // Reset with full buffer and stage 1 occupied
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h11, 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h22, 32'h2);
    tick();
    drive(1'b1, 1'b0, 32'h33, 32'h3);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("mid_full", {31'b0, bus.in_ready}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_res_valid", {31'b0, bus.res_valid}, 32'h0);
    check("mid_acc", bus.acc_q, 32'h0);
    check("mid_in_ready", {31'b0, bus.in_ready}, 32'h1);
    bus.res_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h2, 32'h2);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("post_no_stale", {31'b0, bus.res_valid}, 32'h0);
    tick();
    check("post_valid", {31'b0, bus.res_valid}, 32'h1);
    check("post_sum", bus.res_sum, 32'h4);
    tick();
    check("post_drained", {31'b0, bus.res_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
